button_debouncer: RTL

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/debounce_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/button_debouncer.sv | 106 ++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared state encoding and helpers for the push-button conditioning stages.
// Sibling button blocks import this so every stage agrees on the 2-bit state map.
package debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'b00,
        PRESS_CHK   = 2'b01,
        PRESSED     = 2'b10,
        RELEASE_CHK = 2'b11
    } state_t;

    // The debounced level stays high while a release is still being qualified.
    function automatic logic level_of(input state_t st);
        return (st == PRESSED) || (st == RELEASE_CHK);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops clear to 0 on reset.
module sync_2ff (
    input  logic CLK_FPGA,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge CLK_FPGA or negedge RST_N) begin
        if (!RST_N) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: normalize, synchronize, then require DEBOUNCE_CYCLES stable
// samples before accepting a level change; emits registered level and edge strobes.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic CLK_FPGA,
    input  logic RST_N,
    input  logic BTN_RAW,
    output logic Btn,
    output logic Btn_Press,
    output logic Btn_Release
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_norm;
    logic             s;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             btn_reg, btn_next;
    logic             press_reg, press_next;
    logic             release_reg, release_next;

    assign btn_norm = BTN_RAW ^ BTN_ACTIVE_LOW;

    sync_2ff u_sync (
        .CLK_FPGA (CLK_FPGA),
        .RST_N    (RST_N),
        .d        (btn_norm),
        .q        (s)
    );

    always_ff @(posedge CLK_FPGA or negedge RST_N) begin
        if (!RST_N) begin
            state_reg   <= RELEASED;
            cnt_reg     <= '0;
            btn_reg     <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            btn_reg     <= btn_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RELEASED: begin
                if (s) begin
                    state_next = PRESS_CHK;
                    cnt_next   = '0;
                end
            end
            PRESS_CHK: begin
                // A bounce at any point, including the last check cycle, aborts.
                if (!s) begin
                    state_next = RELEASED;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = PRESSED;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_next = RELEASE_CHK;
                    cnt_next   = '0;
                end
            end
            RELEASE_CHK: begin
                if (s) begin
                    state_next = PRESSED;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = RELEASED;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are computed from the upcoming state so they register alongside it.
    always_comb begin
        btn_next     = level_of(state_next);
        press_next   = (state_reg == PRESS_CHK)   && (state_next == PRESSED);
        release_next = (state_reg == RELEASE_CHK) && (state_next == RELEASED);
    end

    assign Btn         = btn_reg;
    assign Btn_Press   = press_reg;
    assign Btn_Release = release_reg;

endmodule
